ldm_stm_seq: RTL
================

LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on posedge.
REQ-002 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 Port start, input, 1: one-cycle request to begin a block transfer; sampled only in IDLE.
REQ-004 Port is_load, input, 1: 1 = LDM (memory to registers), 0 = STM (registers to memory).
REQ-005 Ports: reglist input 16 (bit i = register Ri); base input 32 (Rn value); rn input 4; up, pre, wback inputs, 1 each (ARM U/P/W bits); all captured on accepted start.
REQ-006 Port ra, output, 4: register-file read address, used for STM data.
REQ-007 Port rd, input, 32: register-file read data for ra. The register file supplies PC+8 when ra=15.
REQ-008 Ports: mem_req output 1; mem_we output 1; mem_addr output 32; mem_wdata output 32; mem_ready input 1; mem_rdata input 32.
REQ-009 Ports: rf_we output 1; rf_a output 4; rf_wd output 32: register-file write port.
REQ-010 Ports: pc_we output 1; pc_wd output 32: PC load, used when an LDM loads R15.
REQ-011 Ports: busy output 1; done output 1 (one-cycle completion pulse).

Function
REQ-012 FSM states: IDLE, XFER, WB, FIN. Only these four states are legal.
REQ-013 IDLE with start=1: capture the inputs, count N = popcount(reglist), and compute the start address. Go to XFER if N>0, otherwise go to FIN.
REQ-014 Start address by mode:
- IA (U=1,P=0): base
- IB (U=1,P=1): base+4
- DA (U=0,P=0): base-4N+4
- DB (U=0,P=1): base-4N
All arithmetic is modulo 2^32.
REQ-015 Transfer order: registers go lowest-numbered first, at ascending addresses (stride +4) for every mode.
REQ-016 In XFER: cur = lowest set bit of the remaining list. Drive mem_req=1, mem_addr = current address, mem_we = !is_load, ra = cur, mem_wdata = rd (combinational).
REQ-017 A beat completes in any XFER cycle with mem_ready=1. Until then, hold all outputs stable; mem_ready may stay low for any number of cycles.
REQ-018 LDM beat completion:
- cur<15: rf_we=1, rf_a=cur, rf_wd=mem_rdata in the same cycle.
- cur=15: pc_we=1, pc_wd=mem_rdata, and rf_we stays 0.
REQ-019 On beat completion: clear cur from the remaining list and advance the address by 4. After the last beat, go to WB if the writeback condition holds, otherwise go to FIN.
REQ-020 Writeback condition: wback=1, and NOT (is_load=1 and reglist[rn]=1). When the loaded value wins, the base update is suppressed.
REQ-021 WB, one cycle:
- rf_we=1, rf_a=rn
- rf_wd = base+4N if up=1, else base-4N
- go to FIN.
REQ-022 FIN, one cycle: done=1, then go to IDLE.
REQ-023 busy=1 in XFER, WB and FIN; busy=0 in IDLE. start is ignored while busy=1.
REQ-024 Empty reglist: no memory access, no register write and no writeback; done is asserted 1 cycle after start.
REQ-025 mem_req, rf_we and pc_we are never asserted in IDLE or FIN. Register writes occur only as specified in REQ-018 and REQ-021.

Reset
REQ-026 reset_n=0 forces IDLE immediately, in any state. busy, done, mem_req, mem_we, rf_we and pc_we go to 0; mem_addr, ra, rf_a, rf_wd, pc_wd and mem_wdata go to 0.
REQ-027 Reset during XFER aborts the transfer. No further beats or writes occur after reset_n returns high until a new start.

Verification
REQ-028 LDMIA, base=0x100, reglist=0x000E, wback=1, rn=0, mem_ready=1:
- reads 0x100/0x104/0x108 write R1/R2/R3 on consecutive cycles
- WB writes R0=0x10C
- done pulses on cycle 5 after start.
REQ-029 STMDB, base=0x200, reglist=0x8003, rn=13, wback=1:
- mem_addr 0x1F4/0x1F8/0x1FC with ra 0/1/15, mem_we=1
- WB writes R13=0x1F4.
REQ-030 LDMIB with reglist containing rn=2, wback=1: addresses start at base+4, and no WB cycle occurs (R2 holds the loaded value). Also: R15 in an LDM list gives pc_we=1 with rf_we=0.
REQ-031 mem_ready held low 3 cycles on beat 2: mem_addr and ra stay stable, no rf_we until mem_ready=1, and the total latency grows by exactly 3.
REQ-032 reglist=0 with start=1: done=1 the next cycle, with no mem_req, rf_we or pc_we ever asserted.
REQ-033 reset_n pulsed low mid-XFER: busy=0 and mem_req=0 immediately, with no writes afterward. A second start pulsed while busy is ignored.

Source files
------------

// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: ARM-style LDM/STM block-transfer sequencer.
// Walks the register list lowest-first at ascending addresses.
// Optionally writes the updated base back to Rn.
module ldm_stm_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_load,
    input  logic [15:0] reglist,
    input  logic [31:0] base,
    input  logic [3:0]  rn,
    input  logic        up,
    input  logic        pre,
    input  logic        wback,
    output logic [3:0]  ra,
    input  logic [31:0] rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_a,
    output logic [31:0] rf_wd,
    output logic        pc_we,
    output logic [31:0] pc_wd,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW = 32;
    localparam int unsigned NREG = 16;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, XFER, WB, FIN} state_t;

    state_t          state;
    logic [NREG-1:0] remaining;
    logic [AW-1:0]   addr_q;
    logic            load_q;
    logic [3:0]      rn_q;
    logic            wb_q;
    logic [AW-1:0]   wb_val_q;

    logic [CW-1:0]   cnt_c;
    logic [AW-1:0]   off_c;
    logic [AW-1:0]   start_addr_c;
    logic [3:0]      cur_c;
    logic            last_c;

    function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
        popcount = '0;
        for (int i = 0; i < NREG; i++) popcount = popcount + CW'(v[i]);
    endfunction

    function automatic logic [3:0] lowest_bit(input logic [NREG-1:0] v);
        lowest_bit = 4'd0;
        for (int i = NREG - 1; i >= 0; i--) if (v[i]) lowest_bit = 4'(i);
    endfunction

    // Start-of-transfer arithmetic and current-beat selection
    always_comb begin
        cnt_c  = popcount(reglist);
        off_c  = {25'd0, cnt_c, 2'b00};
        if (up) start_addr_c = pre ? base + 32'd4 : base;
        else    start_addr_c = pre ? base - off_c : base - off_c + 32'd4;
        cur_c  = lowest_bit(remaining);
        last_c = (remaining & (remaining - 16'd1)) == 16'd0;
    end

    // Sequencer state and captured transfer context
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            addr_q    <= '0;
            load_q    <= 1'b0;
            rn_q      <= '0;
            wb_q      <= 1'b0;
            wb_val_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        load_q    <= is_load;
                        rn_q      <= rn;
                        // A loaded Rn takes precedence over the base update
                        wb_q      <= wback && !(is_load && reglist[rn]);
                        wb_val_q  <= up ? base + off_c : base - off_c;
                        remaining <= reglist;
                        addr_q    <= start_addr_c;
                        state     <= (cnt_c != '0) ? XFER : FIN;
                    end
                end
                XFER: begin
                    if (mem_ready) begin
                        remaining <= remaining & (remaining - 16'd1);
                        addr_q    <= addr_q + 32'd4;
                        if (last_c) state <= wb_q ? WB : FIN;
                    end
                end
                WB:      state <= FIN;
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode from state; load write-back follows mem_ready in-cycle
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ra        = '0;
        rf_we     = 1'b0;
        rf_a      = '0;
        rf_wd     = '0;
        pc_we     = 1'b0;
        pc_wd     = '0;
        case (state)
            XFER: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = !load_q;
                mem_addr  = addr_q;
                ra        = cur_c;
                mem_wdata = rd;
                if (mem_ready && load_q) begin
                    if (cur_c == 4'd15) begin
                        pc_we = 1'b1;
                        pc_wd = mem_rdata;
                    end else begin
                        rf_we = 1'b1;
                        rf_a  = cur_c;
                        rf_wd = mem_rdata;
                    end
                end
            end
            WB: begin
                busy  = 1'b1;
                rf_we = 1'b1;
                rf_a  = rn_q;
                rf_wd = wb_val_q;
            end
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
